rst_sequencer: RTL and testbench
================================

RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter SyncStages, default 2: flops in each input synchronizer, minimum 2.
REQ-002 SHALL have parameter HoldCycles, default 1024: clk_i cycles all resets stay asserted after entering HOLD, minimum 1.
REQ-003 SHALL have parameter StageGapCycles, default 16: clk_i cycles between periph and core release, minimum 1.
REQ-004 SHALL have parameter DebounceCycles, default 50000: consecutive synchronized-low cycles that qualify a button press, minimum 1.
REQ-005 SHALL have port clk_i, input, 1: system clock from the PLL stage; the block's only clock.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous active-low reset (PLL lock ANDed with board reset).
REQ-007 SHALL have port btn_rst_ni, input, 1: raw asynchronous push-button reset, active low.
REQ-008 SHALL have port ndm_reset_req_i, input, 1: clk_i-synchronous debug non-debug-module reset request, level.
REQ-009 SHALL have port rst_dbg_no, output, 1: debug-domain reset, active low.
REQ-010 SHALL have port rst_periph_no, output, 1: peripheral-domain reset, active low.
REQ-011 SHALL have port rst_core_no, output, 1: core-domain reset, active low.
REQ-012 SHALL have port rst_cause_o, output, 2: cause of the last sequenced reset; bit0 button, bit1 ndm.

Function
REQ-013 SHALL assert all outputs low asynchronously on rst_ni low and deassert only synchronously to clk_i.
REQ-014 SHALL release an internal reset rst_sync_n through a SyncStages-deep flop chain clocked by clk_i, with D tied high and async clear by rst_ni.
REQ-015 SHALL drive rst_dbg_no from rst_sync_n only; button and ndm requests SHALL NOT affect it.
REQ-016 SHALL pass btn_rst_ni through a SyncStages-deep synchronizer preset high on reset.
REQ-017 SHALL debounce with a counter saturating at DebounceCycles: increment while the synchronized button is low, clear to 0 while high, and flag btn_pressed while count == DebounceCycles.
REQ-018 SHALL form req = btn_pressed | ndm_reset_req_i.
REQ-019 SHALL implement FSM states HOLD, PERIPH, RUN; reset state HOLD with cycle counter 0.
REQ-020 In HOLD, req high SHALL hold the counter at 0; otherwise it increments, and at count HoldCycles-1 the FSM goes to PERIPH with counter cleared.
REQ-021 In PERIPH, the counter SHALL increment; at count StageGapCycles-1 the FSM goes to RUN.
REQ-022 In PERIPH or RUN, req high SHALL transition to HOLD with counter cleared; req takes priority over counter expiry in the same cycle.
REQ-023 SHALL register the outputs from state: rst_periph_no = 1 in PERIPH and RUN; rst_core_no = 1 in RUN only.
REQ-024 After any reset release, rst_periph_no SHALL go high exactly HoldCycles cycles after rst_sync_n goes high or req drops, and rst_core_no SHALL follow exactly StageGapCycles cycles later.
REQ-025 On a PERIPH/RUN->HOLD transition, rst_periph_no and rst_core_no SHALL go low on the clock edge following the cycle req is first seen high.
REQ-026 On a PERIPH/RUN->HOLD transition, rst_cause_o SHALL load {ndm_reset_req_i, btn_pressed}; when both are high, both bits set.
REQ-027 rst_cause_o SHALL hold its value otherwise and SHALL NOT change for req seen while already in HOLD.
REQ-028 Counter width SHALL be $clog2(max(HoldCycles, StageGapCycles)+1), and the counter SHALL never wrap.
REQ-029 Debounce counter width SHALL be $clog2(DebounceCycles+1) and it SHALL saturate without wrapping.

Reset
REQ-030 Under rst_ni low, SHALL hold rst_dbg_no=0, rst_periph_no=0, rst_core_no=0, rst_cause_o=2'b00, FSM=HOLD, both counters 0, and synchronizers in the inactive state.
REQ-031 rst_ni low mid-sequence (any state) SHALL immediately re-assert all outputs, clear rst_cause_o, and restart the full sequence on release.

Verification (SyncStages=2, HoldCycles=16, StageGapCycles=4, DebounceCycles=8)
REQ-032 Bench SHALL cover power-on: release rst_ni -> rst_dbg_no high after 2 edges, rst_periph_no 16 cycles later, rst_core_no 4 cycles after that; cause 00.
REQ-033 Bench SHALL cover a glitch in RUN: btn_rst_ni low 5 cycles -> no output change, cause unchanged.
REQ-034 Bench SHALL cover a press in RUN: btn_rst_ni low 40 cycles -> periph/core low 2+8+1 cycles after press, held while pressed, re-released 16 and 20 cycles after btn_pressed drops; cause 01; rst_dbg_no stays high.
REQ-035 Bench SHALL cover ndm in PERIPH: ndm_reset_req_i pulse 1 cycle -> periph low next edge, core stays low, sequence restarts; cause 10.
REQ-036 Bench SHALL cover simultaneous requests: ndm and qualified button in the same cycle in RUN -> cause 11.
REQ-037 Bench SHALL cover reset mid-sequence: rst_ni low during PERIPH -> all outputs 0 asynchronously, cause 00, full 2/16/4 sequence on release.

Source files
------------

// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronizes the board reset, debounces a push-button, and
// releases debug, peripheral and core resets in a fixed staged order.
module rst_sequencer #(
  parameter int SyncStages     = 2,
  parameter int HoldCycles     = 1024,
  parameter int StageGapCycles = 16,
  parameter int DebounceCycles = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_rst_ni,
  input  logic       ndm_reset_req_i,
  output logic       rst_dbg_no,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic [1:0] rst_cause_o
);

  localparam int MaxCycles = (HoldCycles > StageGapCycles) ? HoldCycles : StageGapCycles;
  localparam int CntW      = $clog2(MaxCycles + 1);
  localparam int DbW       = $clog2(DebounceCycles + 1);

  localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(StageGapCycles - 1);
  localparam logic [DbW-1:0]  DbMax    = DbW'(DebounceCycles);

  typedef enum logic [1:0] {
    HOLD,
    PERIPH,
    RUN
  } state_e;

  logic [SyncStages-1:0] rst_sync_d, rst_sync_q;
  logic [SyncStages-1:0] btn_sync_d, btn_sync_q;
  logic [DbW-1:0]        db_cnt_d, db_cnt_q;
  logic [CntW-1:0]       cnt_d, cnt_q;
  logic [1:0]            cause_d, cause_q;
  state_e                state_d, state_q;
  logic                  periph_d, periph_q;
  logic                  core_d, core_q;

  logic rst_sync_n;
  logic btn_sync_n;
  logic btn_pressed;
  logic req;

  always_comb begin
    rst_sync_d = {rst_sync_q[SyncStages-2:0], 1'b1};
    btn_sync_d = {btn_sync_q[SyncStages-2:0], btn_rst_ni};
  end

  assign rst_sync_n = rst_sync_q[SyncStages-1];
  assign btn_sync_n = btn_sync_q[SyncStages-1];

  // Saturating count of consecutive low samples; a press is a full-length run.
  always_comb begin
    db_cnt_d = db_cnt_q;
    if (btn_sync_n) begin
      db_cnt_d = '0;
    end else if (db_cnt_q != DbMax) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign btn_pressed = (db_cnt_q == DbMax);
  assign req         = btn_pressed | ndm_reset_req_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    if (!rst_sync_n) begin
      state_d = HOLD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (req) begin
            cnt_d = '0;
          end else if (cnt_q == HoldLast) begin
            state_d = PERIPH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PERIPH: begin
          if (req) begin
            state_d = HOLD;
            cnt_d   = '0;
            cause_d = {ndm_reset_req_i, btn_pressed};
          end else if (cnt_q == GapLast) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (req) begin
            state_d = HOLD;
            cnt_d   = '0;
            cause_d = {ndm_reset_req_i, btn_pressed};
          end
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs come from the next state so the registered copies line up with state_q.
  always_comb begin
    periph_d = (state_d == PERIPH) || (state_d == RUN);
    core_d   = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_sync_q <= '0;
      btn_sync_q <= '1;
      db_cnt_q   <= '0;
      state_q    <= HOLD;
      cnt_q      <= '0;
      cause_q    <= 2'b00;
      periph_q   <= 1'b0;
      core_q     <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      btn_sync_q <= btn_sync_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      periph_q   <= periph_d;
      core_q     <= core_d;
    end
  end

  assign rst_dbg_no    = rst_sync_n;
  assign rst_periph_no = periph_q;
  assign rst_core_no   = core_q;
  assign rst_cause_o   = cause_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: directed vector table, staged-release
// sequences, async reset mid-sequence, and randomized traffic against a run-length model.
module tb_rst_sequencer;

  localparam int SyncStages     = 2;
  localparam int HoldCycles     = 16;
  localparam int StageGapCycles = 4;
  localparam int DebounceCycles = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       btn_rst_ni;
  logic       ndm_reset_req_i;
  logic       rst_dbg_no;
  logic       rst_periph_no;
  logic       rst_core_no;
  logic [1:0] rst_cause_o;

  int checkCount = 0;
  int passCount  = 0;

  // Model state: reset edges seen, run lengths of quiet cycles and of low button samples.
  int         rstEdges;
  bit         syncUp;
  int         quietRun;
  int         lowRun;
  bit         btnHist[$];
  logic [1:0] mCause;

  typedef struct {
    string      name;
    int         cycles;
    bit         btn;
    bit         ndm;
    bit         expDbg;
    bit         expPeriph;
    bit         expCore;
    logic [1:0] expCause;
  } vec_t;

  vec_t vecs[$];

  rst_sequencer #(
    .SyncStages    (SyncStages),
    .HoldCycles    (HoldCycles),
    .StageGapCycles(StageGapCycles),
    .DebounceCycles(DebounceCycles)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .btn_rst_ni     (btn_rst_ni),
    .ndm_reset_req_i(ndm_reset_req_i),
    .rst_dbg_no     (rst_dbg_no),
    .rst_periph_no  (rst_periph_no),
    .rst_core_no    (rst_core_no),
    .rst_cause_o    (rst_cause_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(string n, int c, bit b, bit nd, bit d, bit p, bit co,
                                 logic [1:0] ca);
    vec_t v;
    v.name = n; v.cycles = c; v.btn = b; v.ndm = nd;
    v.expDbg = d; v.expPeriph = p; v.expCore = co; v.expCause = ca;
    return v;
  endfunction

  task automatic modelReset();
    rstEdges = 0;
    syncUp   = 1'b0;
    quietRun = 0;
    lowRun   = 0;
    mCause   = 2'b00;
    btnHist.delete();
    for (int i = 0; i < SyncStages; i++) btnHist.push_back(1'b1);
  endtask

  // A cycle is quiet when the synchronized reset is up and no request is present;
  // periph releases after HoldCycles quiet cycles, core StageGapCycles later.
  task automatic modelEdge();
    bit pressed;
    bit req;
    bit btnS;
    if (!rst_ni) begin
      modelReset();
      return;
    end
    pressed = (lowRun >= DebounceCycles);
    req     = pressed | ndm_reset_req_i;
    if (req && quietRun >= HoldCycles) mCause = {ndm_reset_req_i, pressed};
    if (syncUp && !req) quietRun++;
    else quietRun = 0;
    btnS   = btnHist[0];
    lowRun = btnS ? 0 : lowRun + 1;
    btnHist.push_back(btn_rst_ni);
    void'(btnHist.pop_front());
    if (rstEdges < SyncStages) rstEdges++;
    syncUp = (rstEdges >= SyncStages);
  endtask

  task automatic step();
    @(posedge clk_i);
    modelEdge();
    #1;
  endtask

  task automatic checkOutput(string name, bit d, bit p, bit c, logic [1:0] ca);
    checkCount++;
    if ({rst_dbg_no, rst_periph_no, rst_core_no, rst_cause_o} === {d, p, c, ca}) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got dbg=%b periph=%b core=%b cause=%b, expected dbg=%b periph=%b core=%b cause=%b",
               name, rst_dbg_no, rst_periph_no, rst_core_no, rst_cause_o, d, p, c, ca);
    end
  endtask

  task automatic checkModel(string name);
    checkOutput(name, syncUp, quietRun >= HoldCycles,
                quietRun >= HoldCycles + StageGapCycles, mCause);
  endtask

  task automatic applyStimulus(vec_t v);
    btn_rst_ni      = v.btn;
    ndm_reset_req_i = v.ndm;
    repeat (v.cycles) begin
      step();
      checkModel({v.name, "_model"});
    end
    checkOutput(v.name, v.expDbg, v.expPeriph, v.expCore, v.expCause);
  endtask

  // Releases rst_ni just after an edge and checks the 2/16/4 staging edge by edge.
  task automatic powerOn(string name);
    rst_ni = 1'b1;
    for (int i = 1; i <= SyncStages + HoldCycles + StageGapCycles + 2; i++) begin
      step();
      checkOutput(name, i >= SyncStages, i >= SyncStages + HoldCycles,
                  i >= SyncStages + HoldCycles + StageGapCycles, 2'b00);
    end
  endtask

  initial begin
    rst_ni          = 1'b0;
    btn_rst_ni      = 1'b1;
    ndm_reset_req_i = 1'b0;
    modelReset();

    vecs.push_back(mkVec("glitch_low",  5,  1'b0, 1'b0, 1, 1, 1, 2'b00));
    vecs.push_back(mkVec("glitch_high", 10, 1'b1, 1'b0, 1, 1, 1, 2'b00));
    vecs.push_back(mkVec("press_qual",  10, 1'b0, 1'b0, 1, 1, 1, 2'b00));
    vecs.push_back(mkVec("press_hit",   1,  1'b0, 1'b0, 1, 0, 0, 2'b01));
    vecs.push_back(mkVec("press_hold",  29, 1'b0, 1'b0, 1, 0, 0, 2'b01));
    vecs.push_back(mkVec("rel_hold",    18, 1'b1, 1'b0, 1, 0, 0, 2'b01));
    vecs.push_back(mkVec("rel_periph",  1,  1'b1, 1'b0, 1, 1, 0, 2'b01));
    vecs.push_back(mkVec("rel_gap",     3,  1'b1, 1'b0, 1, 1, 0, 2'b01));
    vecs.push_back(mkVec("rel_core",    1,  1'b1, 1'b0, 1, 1, 1, 2'b01));
    vecs.push_back(mkVec("both_qual",   10, 1'b0, 1'b0, 1, 1, 1, 2'b01));
    vecs.push_back(mkVec("both_hit",    1,  1'b0, 1'b1, 1, 0, 0, 2'b11));
    vecs.push_back(mkVec("both_rel",    1,  1'b1, 1'b0, 1, 0, 0, 2'b11));
    vecs.push_back(mkVec("both_wait",   18, 1'b1, 1'b0, 1, 1, 0, 2'b11));
    vecs.push_back(mkVec("ndm_pulse",   1,  1'b1, 1'b1, 1, 0, 0, 2'b10));
    vecs.push_back(mkVec("ndm_hold",    15, 1'b1, 1'b0, 1, 0, 0, 2'b10));
    vecs.push_back(mkVec("ndm_periph",  1,  1'b1, 1'b0, 1, 1, 0, 2'b10));
    vecs.push_back(mkVec("ndm_gap",     3,  1'b1, 1'b0, 1, 1, 0, 2'b10));

    step();
    step();
    checkOutput("reset_state", 1'b0, 1'b0, 1'b0, 2'b00);
    powerOn("power_on");

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Sequencer now sits in PERIPH; pull rst_ni low between edges.
    #3;
    rst_ni = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 2'b00);
    step();
    checkOutput("reset_held", 1'b0, 1'b0, 1'b0, 2'b00);
    powerOn("restart");

    for (int s = 0; s < 45; s++) begin
      int len;
      btn_rst_ni = $urandom_range(0, 1);
      len = btn_rst_ni ? $urandom_range(1, 30) : $urandom_range(1, 20);
      for (int c = 0; c < len; c++) begin
        ndm_reset_req_i = ($urandom_range(0, 39) == 0);
        step();
        checkModel("random");
      end
      if ($urandom_range(0, 9) == 0) begin
        #2;
        rst_ni = 1'b0;
        #1;
        modelReset();
        checkModel("random_async");
        step();
        rst_ni = 1'b1;
      end
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
